// File: rtl/act_seq_ctrl.sv
// rtl/act_seq_ctrl.sv - job sequencer streaming a tensor through a leaky-ReLU lane
// Optional macro ACT_NEG_COUNT_EN adds the neg_count output.
module act_seq_ctrl #(
  parameter int DATA_WIDTH  = 16,
  parameter int ADDR_WIDTH  = 10,
  parameter int ALPHA_SHIFT = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] src_base,
  input  logic [ADDR_WIDTH-1:0] dst_base,
  input  logic [ADDR_WIDTH:0]   len,
  output logic                  busy,
  output logic                  done,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_ready
`ifdef ACT_NEG_COUNT_EN
  ,
  output logic [ADDR_WIDTH:0]   neg_count
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t                r_state, w_next;
  logic [ADDR_WIDTH:0]   r_len, r_rd_cnt, r_wr_cnt;
  logic [ADDR_WIDTH-1:0] r_src_ptr, r_dst_ptr;
  logic                  r_rd_pend;
  logic [DATA_WIDTH-1:0] r_skid0, r_skid1;
  logic [1:0]            r_skid_cnt;
  logic                  r_wr_en;
  logic [ADDR_WIDTH-1:0] r_wr_addr;
  logic [DATA_WIDTH-1:0] r_wr_data;

  logic                         w_start_ok, w_rd_en, w_rd_last, w_wr_last;
  logic                         w_fire, w_out_free, w_load;
  logic [1:0]                   w_occ;
  logic signed [DATA_WIDTH-1:0] w_rd_s, w_neg_shift;
  logic [DATA_WIDTH-1:0]        w_act;

  assign w_occ      = r_skid_cnt + {1'b0, r_rd_pend};
  assign w_fire     = r_wr_en && wr_ready;
  assign w_out_free = !r_wr_en || wr_ready;
  assign w_load     = w_out_free && ((r_skid_cnt != 2'd0) || r_rd_pend);
  assign w_rd_last  = (r_rd_cnt + 1'b1) == r_len;
  assign w_wr_last  = (r_wr_cnt + 1'b1) == r_len;

  // Shift kept in its own signed net so the select below cannot demote it to a logical shift.
  assign w_rd_s      = rd_data;
  assign w_neg_shift = w_rd_s >>> ALPHA_SHIFT;
  assign w_act       = rd_data[DATA_WIDTH-1] ? w_neg_shift : rd_data;

  always_comb begin
    w_next     = r_state;
    w_rd_en    = 1'b0;
    w_start_ok = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_start_ok = 1'b1;
          w_next     = (len == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        w_rd_en = (r_rd_cnt != r_len) && (w_occ < 2'd2);
        if (w_rd_en && w_rd_last) w_next = S_DRAIN;
      end
      S_DRAIN: begin
        if (w_fire && w_wr_last) w_next = S_DONE;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_len      <= '0;
      r_rd_cnt   <= '0;
      r_wr_cnt   <= '0;
      r_src_ptr  <= '0;
      r_dst_ptr  <= '0;
      r_rd_pend  <= 1'b0;
      r_skid0    <= '0;
      r_skid1    <= '0;
      r_skid_cnt <= 2'd0;
      r_wr_en    <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
    end else begin
      r_state   <= w_next;
      r_rd_pend <= w_rd_en;

      if (w_start_ok) begin
        r_len     <= len;
        r_src_ptr <= src_base;
        r_dst_ptr <= dst_base;
        r_rd_cnt  <= '0;
        r_wr_cnt  <= '0;
      end else begin
        if (w_rd_en) begin
          r_src_ptr <= r_src_ptr + 1'b1;
          r_rd_cnt  <= r_rd_cnt + 1'b1;
        end
        if (w_load) r_dst_ptr <= r_dst_ptr + 1'b1;
        if (w_fire) r_wr_cnt <= r_wr_cnt + 1'b1;
      end

      // Oldest skid entry always has priority over the element arriving this cycle.
      if (w_out_free) begin
        r_wr_en <= w_load;
        if (w_load) begin
          r_wr_addr <= r_dst_ptr;
          r_wr_data <= (r_skid_cnt != 2'd0) ? r_skid0 : w_act;
        end
        case (r_skid_cnt)
          2'd1: begin
            if (r_rd_pend) r_skid0 <= w_act;
            else           r_skid_cnt <= 2'd0;
          end
          2'd2: begin
            r_skid0 <= r_skid1;
            if (r_rd_pend) r_skid1 <= w_act;
            else           r_skid_cnt <= 2'd1;
          end
          default: ;
        endcase
      end else if (r_rd_pend) begin
        if (r_skid_cnt == 2'd0) r_skid0 <= w_act;
        else                    r_skid1 <= w_act;
        r_skid_cnt <= r_skid_cnt + 2'd1;
      end
    end
  end

`ifdef ACT_NEG_COUNT_EN
  logic [ADDR_WIDTH:0] r_neg_cnt;

  always_ff @(posedge clk) begin
    if (!rst)                                    r_neg_cnt <= '0;
    else if (w_start_ok)                         r_neg_cnt <= '0;
    else if (r_rd_pend && rd_data[DATA_WIDTH-1]) r_neg_cnt <= r_neg_cnt + 1'b1;
  end

  assign neg_count = r_neg_cnt;
`endif

  assign busy    = (r_state == S_RUN) || (r_state == S_DRAIN);
  assign done    = (r_state == S_DONE);
  assign rd_en   = w_rd_en;
  assign rd_addr = r_src_ptr;
  assign wr_en   = r_wr_en;
  assign wr_addr = r_wr_addr;
  assign wr_data = r_wr_data;

endmodule

// File: tb/tb_act_seq_ctrl.sv
// tb/tb_act_seq_ctrl.sv - randomized self-checking bench for act_seq_ctrl with a job-level model
module tb_act_seq_ctrl;
  localparam int DW   = 16;
  localparam int AW   = 4;
  localparam int SH   = 7;
  localparam int NBUF = 1 << AW;
  localparam int DIV  = 1 << SH;

  logic          clk = 1'b0;
  logic          rst, start, busy, done, rd_en, wr_en, wr_ready;
  logic [AW-1:0] src_base, dst_base, rd_addr, wr_addr;
  logic [AW:0]   len;
  logic [DW-1:0] rd_data, wr_data;
`ifdef ACT_NEG_COUNT_EN
  logic [AW:0]   neg_count;
`endif

  always #5 clk = ~clk;

  act_seq_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ALPHA_SHIFT(SH)) dut (
    .clk(clk), .rst(rst), .start(start), .src_base(src_base), .dst_base(dst_base), .len(len),
    .busy(busy), .done(done), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready)
`ifdef ACT_NEG_COUNT_EN
    , .neg_count(neg_count)
`endif
  );

  typedef struct {int addr; int data;} wr_t;

  logic [DW-1:0] mem [NBUF];
  wr_t           exp_q [$];
  int            rd_log [$];
  int            wr_log_addr [$];
  int            wr_log_data [$];
  int            n_cmp = 0, n_fail = 0, cyc = 0;
  int            first_rd_cyc, first_wr_cyc, last_wr_cyc, done_cyc, start_acc_cyc, job_wr;
  bit            done_seen;
  int            rmode = 0, ph = 0;

  bit            m_active = 0, m_done_due = 0, post_rst = 0, prev_stall = 0;
  int            m_src, m_len, m_rd_issued, m_wr_done, m_neg;
  logic [AW-1:0] prev_addr;
  logic [DW-1:0] prev_data;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", name, act, act, exp, exp, cyc);
    end
  endtask

  // Leaky ReLU as floor division by 2^SH for negative values.
  function automatic logic [DW-1:0] act_model(input logic [DW-1:0] x);
    int v;
    v = (x[DW-1]) ? int'(x) - (1 << DW) : int'(x);
    if (v < 0) v = -((-v + DIV - 1) / DIV);
    return DW'(v);
  endfunction

  // Source RAM: data appears the cycle after the read strobe.
  always begin
    logic          req;
    logic [AW-1:0] a;
    @(negedge clk);
    req = rd_en;
    a   = rd_addr;
    @(posedge clk);
    #1;
    rd_data = req ? mem[a] : DW'($urandom);
  end

  always begin
    @(posedge clk);
    #1;
    case (rmode)
      0: wr_ready = 1'b1;
      1: begin wr_ready = (ph % 4 == 0) || (ph % 4 == 3); ph++; end
      2: wr_ready = ($urandom_range(0, 3) != 0);
      default: ;
    endcase
  end

  always @(negedge clk) begin
    bit  n_active, n_done, fire;
    wr_t e;
    cyc++;
    if (!rst) begin
      exp_q.delete();
      m_active   = 0;
      m_done_due = 0;
      prev_stall = 0;
      post_rst   = 1;
    end else begin
      if (post_rst) begin
        chk("reset_ctrl", {busy, done, rd_en, wr_en}, 0);
        chk("reset_addr", {rd_addr, wr_addr}, 0);
        chk("reset_wdata", wr_data, 0);
        post_rst = 0;
      end
      n_active = m_active;
      n_done   = 0;
      chk("done", done, m_done_due);
      chk("busy", busy, m_active);
      if (done) begin
        done_seen = 1;
        done_cyc  = cyc;
`ifdef ACT_NEG_COUNT_EN
        chk("neg_count", neg_count, m_neg);
`endif
      end
      if (m_active) chk("outstanding_le2", (m_rd_issued - m_wr_done - int'(wr_en)) <= 2, 1);
      if (rd_en) begin
        chk("rd_allowed", m_active && (m_rd_issued < m_len), 1);
        chk("rd_addr", rd_addr, (m_src + m_rd_issued) % NBUF);
        chk("rd_issue_rule", (m_rd_issued - m_wr_done - int'(wr_en)) < 2, 1);
        if (rd_log.size() == 0) first_rd_cyc = cyc;
        rd_log.push_back(int'(rd_addr));
        m_rd_issued++;
      end
      if (prev_stall) begin
        chk("hold_en", wr_en, 1);
        chk("hold_addr", wr_addr, prev_addr);
        chk("hold_data", wr_data, prev_data);
      end
      fire = wr_en && wr_ready;
      if (fire) begin
        chk("wr_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          chk("wr_addr", wr_addr, exp_q[0].addr);
          chk("wr_data", wr_data, exp_q[0].data);
          void'(exp_q.pop_front());
          m_wr_done++;
          if (exp_q.size() == 0) begin
            n_active = 0;
            n_done   = 1;
          end
        end
        if (wr_log_addr.size() == 0) first_wr_cyc = cyc;
        last_wr_cyc = cyc;
        wr_log_addr.push_back(int'(wr_addr));
        wr_log_data.push_back(int'(wr_data));
        job_wr++;
      end
      prev_stall = wr_en && !wr_ready;
      prev_addr  = wr_addr;
      prev_data  = wr_data;
      if (!m_active && !m_done_due && start) begin
        start_acc_cyc = cyc;
        m_src         = int'(src_base);
        m_len         = int'(len);
        m_rd_issued   = 0;
        m_wr_done     = 0;
        m_neg         = 0;
        for (int k = 0; k < m_len; k++) begin
          e.addr = (int'(dst_base) + k) % NBUF;
          e.data = int'(act_model(mem[(m_src + k) % NBUF]));
          if (mem[(m_src + k) % NBUF][DW-1]) m_neg++;
          exp_q.push_back(e);
        end
        if (m_len == 0) n_done = 1;
        else            n_active = 1;
      end
      m_active   = n_active;
      m_done_due = n_done;
    end
  end

  task automatic clear_logs();
    rd_log.delete();
    wr_log_addr.delete();
    wr_log_data.delete();
    done_seen    = 0;
    job_wr       = 0;
    first_rd_cyc = -1;
    first_wr_cyc = -1;
    last_wr_cyc  = -1;
    done_cyc     = -1;
  endtask

  task automatic fill_mem();
    for (int k = 0; k < NBUF; k++) mem[k] = DW'($urandom);
  endtask

  task automatic start_pulse(input int s, input int d, input int l);
    @(posedge clk);
    #1;
    src_base = AW'(s);
    dst_base = AW'(d);
    len      = (AW+1)'(l);
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int bound);
    int i;
    i = 0;
    while (!done_seen && i < bound) begin
      @(posedge clk);
      i++;
    end
    chk({name, "_done_seen"}, done_seen, 1);
  endtask

  initial begin
    int i;
    rst = 1'b0; start = 1'b0; src_base = '0; dst_base = '0; len = '0;
    rd_data = '0; wr_ready = 1'b1;
    fill_mem();
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    // basic
    mem[2] = 16'h0064; mem[3] = 16'hFF00; mem[4] = 16'hFFFF;
    clear_logs();
    start_pulse(2, 9, 3);
    wait_done("basic", 40);
    chk("basic_latency", first_wr_cyc - first_rd_cyc, 2);
    chk("basic_last_wr", last_wr_cyc - first_rd_cyc, 4);
    chk("basic_done_after", done_cyc - last_wr_cyc, 1);
    chk("basic_nwr", wr_log_data.size(), 3);
    if (wr_log_data.size() == 3) begin
      chk("basic_d0", wr_log_data[0], 'h0064);
      chk("basic_d1", wr_log_data[1], 'hFFFE);
      chk("basic_d2", wr_log_data[2], 'hFFFF);
      chk("basic_a0", wr_log_addr[0], 9);
      chk("basic_a2", wr_log_addr[2], 11);
    end
`ifdef ACT_NEG_COUNT_EN
    chk("basic_neg", neg_count, 2);
`endif

    // backpressure 1,0,0,1
    fill_mem();
    clear_logs();
    ph = 0;
    rmode = 1;
    start_pulse(0, 4, 8);
    wait_done("bp", 200);
    rmode = 0;
    chk("bp_nwr", wr_log_data.size(), 8);

    // zero length
    clear_logs();
    start_pulse(3, 3, 0);
    wait_done("zero", 10);
    chk("zero_done_delay", done_cyc - start_acc_cyc, 1);
    chk("zero_nrd", rd_log.size(), 0);
    chk("zero_nwr", wr_log_data.size(), 0);

    // start ignored while running
    fill_mem();
    clear_logs();
    start_pulse(1, 6, 4);
    #1 start = 1'b1; src_base = 4'd8; len = 5'd7;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done("ign", 40);
    chk("ign_nwr", wr_log_data.size(), 4);
    repeat (4) @(posedge clk);
    chk("ign_nrd", rd_log.size(), 4);

    // address wrap
    fill_mem();
    clear_logs();
    start_pulse(14, 15, 4);
    wait_done("wrap", 40);
    chk("wrap_nrd", rd_log.size(), 4);
    chk("wrap_nwr", wr_log_addr.size(), 4);
    if (rd_log.size() == 4 && wr_log_addr.size() == 4) begin
      chk("wrap_r2", rd_log[2], 0);
      chk("wrap_r3", rd_log[3], 1);
      chk("wrap_w0", wr_log_addr[0], 15);
      chk("wrap_w1", wr_log_addr[1], 0);
      chk("wrap_w3", wr_log_addr[3], 2);
    end

    // reset mid-job
    fill_mem();
    clear_logs();
    rmode = 3;
    wr_ready = 1'b1;
    start_pulse(0, 0, 10);
    i = 0;
    while (job_wr < 3 && i < 100) begin
      @(posedge clk);
      i++;
    end
    chk("rst_reach3", job_wr, 3);
    #1 rst = 1'b0; wr_ready = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1; wr_ready = 1'b1;
    repeat (8) @(posedge clk);
    chk("rst_no_more_wr", wr_log_data.size(), 3);
    rmode = 0;
    fill_mem();
    clear_logs();
    start_pulse(7, 2, 2);
    wait_done("after_rst", 40);
    chk("after_rst_nwr", wr_log_data.size(), 2);
    chk("after_rst_latency", first_wr_cyc - first_rd_cyc, 2);

    // full buffer
    fill_mem();
    clear_logs();
    start_pulse(5, 3, 16);
    wait_done("full", 100);
    chk("full_nwr", wr_log_data.size(), 16);
    chk("full_last_wr", last_wr_cyc - first_rd_cyc, 17);
    @(negedge clk);
    chk("full_busy_after", busy, 0);

    // random jobs with random backpressure
    for (int j = 0; j < 10; j++) begin
      int l;
      fill_mem();
      clear_logs();
      rmode = 2;
      l = $urandom_range(0, NBUF);
      start_pulse($urandom_range(0, NBUF - 1), $urandom_range(0, NBUF - 1), l);
      wait_done("rand", 400);
      chk("rand_nwr", wr_log_data.size(), l);
    end
    rmode = 0;

    repeat (5) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/act_seq_ctrl.md
Name: act_seq_ctrl

Overview:
- Job-level controller that streams a flattened tensor from a source buffer, through an internal leaky-ReLU lane, into a destination buffer.
- Software or the layer FSM supplies base addresses and element count, then pulses start.
- Sits between the activation buffer RAMs and the residual-block top. It replaces per-element activation instances with one sequenced, back-pressurable lane.

Parameters:
- DATA_WIDTH, 16, element width (signed fixed-point).
- ADDR_WIDTH, 10, buffer address width.
- ALPHA_SHIFT, 7, arithmetic right shift applied to negative elements (alpha = 2^-ALPHA_SHIFT).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-low reset.
- start  in  1  job start; sampled only in IDLE.
- src_base  in  ADDR_WIDTH  first source address; latched on accepted start.
- dst_base  in  ADDR_WIDTH  first destination address; latched on accepted start.
- len  in  ADDR_WIDTH+1  element count, 0..2^ADDR_WIDTH; latched on accepted start.
- busy  out  1  high in RUN/DRAIN.
- done  out  1  one-cycle pulse at job end.
- rd_en  out  1  source read strobe.
- rd_addr  out  ADDR_WIDTH  source address.
- rd_data  in  DATA_WIDTH  source data, valid exactly 1 cycle after rd_en.
- wr_en  out  1  destination write valid.
- wr_addr  out  ADDR_WIDTH  destination address.
- wr_data  out  DATA_WIDTH  activated element.
- wr_ready  in  1  destination accepts; a write completes in any cycle with wr_en && wr_ready.

Behaviour:
- Reset (rst=0 at a clk edge): FSM to IDLE; busy, done, rd_en, wr_en = 0; addresses, wr_data, counters = 0; skid buffer emptied.
  - Reset mid-job abandons the job. No rd_en/wr_en after release until a new start.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE: start=1 latches bases and len.
    - len=0 goes to DONE.
    - Otherwise goes to RUN.
  - RUN: issue reads at src_base, src_base+1, … until len reads have been issued, then go to DRAIN.
  - DRAIN: wait until len writes have completed, then go to DONE.
  - DONE: done=1 for exactly one cycle, then go to IDLE.
  - start outside IDLE is ignored.
- Read issue rule: rd_en asserted in RUN only when (reads in flight + skid entries occupied) < 2. In-flight means issued but data not yet captured.
- Datapath:
  - rd_data is captured the cycle after rd_en.
  - Activation: if bit DATA_WIDTH-1 is set, result = rd_data >>> ALPHA_SHIFT (sign-extending); else result = rd_data.
  - Result is loaded into the registered output wr_data/wr_addr/wr_en, or into the 2-entry skid buffer when the output is held.
- Latency: first wr_en rises 2 cycles after the first rd_en.
- Throughput: 1 element/cycle while wr_ready=1. A job of len N with wr_ready tied high completes its last write N+1 cycles after its first rd_en.
- Backpressure: while wr_en=1 and wr_ready=0, wr_addr and wr_data hold stable. No element is dropped or duplicated. Read issue stalls per the issue rule.
- Ordering: writes occur in strict address order, dst_base+k for element src_base+k.
- Address wrap: src/dst addresses increment modulo 2^ADDR_WIDTH. len = 2^ADDR_WIDTH covers the whole buffer exactly once.
- Counters are ADDR_WIDTH+1 bits. No overflow is possible at len = 2^ADDR_WIDTH.
- done and the final write: done never asserts in the same cycle as the final accepted write; it asserts the following cycle.

Optional Feature:
- Macro: ACT_NEG_COUNT_EN.
- Defined: adds output neg_count (ADDR_WIDTH+1 bits).
  - Cleared on accepted start.
  - Incremented once per element whose sign bit is set.
  - Stable and valid from the DONE cycle until the next accepted start.
  - Reset to 0.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Basic, wr_ready=1: len=3, src data {0x0064, 0xFF00, 0xFFFF} -> writes {0x0064, 0xFFFE, 0xFFFF} to dst_base..+2. First wr_en 2 cycles after first rd_en. done one cycle after the third write. With ACT_NEG_COUNT_EN, neg_count=2.
- Backpressure: len=8, wr_ready toggled 1,0,0,1 repeatedly -> exactly 8 writes in order, with wr_data/wr_addr stable during every wr_ready=0 cycle. Never more than 2 reads outstanding+buffered.
- Zero length and ignored start: len=0 -> done pulses the cycle after IDLE→DONE, with no rd_en/wr_en. A start pulse during RUN of a len=4 job is ignored, and only that 4-element job executes.
- Wrap: ADDR_WIDTH=4, src_base=14, dst_base=15, len=4 -> reads at 14,15,0,1 and writes at 15,0,1,2.
- Reset mid-job: rst=0 for one cycle after 3 of 10 writes -> busy=0, wr_en=0 next cycle, no further writes. A new start with len=2 then behaves like a fresh job.
- Full buffer: ADDR_WIDTH=4, len=16, wr_ready=1 -> 16 writes, done asserted, busy low afterwards.
